// File: rtl/control_enable_pipeline.sv
// control_enable_pipeline
// Sequencer that gates the enable of every pipeline stage. A host issues
// RUN / STEP / STOP commands; when the execution stage reports a halt the
// controller keeps the pipeline enabled for CICLOS_DRAIN more cycles so the
// MEM and WB stages can retire, then parks in DONE until reset.
//
// Ports
//   i_clock          rising-edge clock
//   i_soft_reset     synchronous reset, active low
//   i_cmd_valid      command strobe (taken when o_cmd_ready is also high)
//   i_cmd            00 NOP, 01 RUN, 10 STEP, 11 STOP
//   i_halt_detected  halt flag from the execution stage output
//   o_enable_pipeline registered enable to all pipeline stages
//   o_cmd_ready      a command can be accepted this cycle
//   o_busy           high in RUN, STEP, DRAIN
//   o_done           halt fully drained; held until reset
//   o_cycle_count    saturating count of cycles with the enable high
//
// state | meaning
// IDLE  | pipeline frozen, waiting for RUN or STEP
// RUN   | free running; only STOP or a halt leaves
// STEP  | single enabled cycle, then back to IDLE
// DRAIN | halt seen, flushing MEM/WB for CICLOS_DRAIN cycles
// DONE  | program finished; only reset leaves

module control_enable_pipeline #(
    parameter int CANT_BITS_CONTADOR = 32,
    parameter int CANT_BITS_CMD      = 2,
    parameter int CICLOS_DRAIN       = 2
) (
    input  logic                          i_clock,
    input  logic                          i_soft_reset,
    input  logic                          i_cmd_valid,
    input  logic [CANT_BITS_CMD-1:0]      i_cmd,
    input  logic                          i_halt_detected,
    output logic                          o_enable_pipeline,
    output logic                          o_cmd_ready,
    output logic                          o_busy,
    output logic                          o_done,
    output logic [CANT_BITS_CONTADOR-1:0] o_cycle_count
);

    localparam int DRAIN_W = (CICLOS_DRAIN < 2) ? 1 : $clog2(CICLOS_DRAIN + 1);
    localparam logic [DRAIN_W-1:0]       DRAIN_LOAD = DRAIN_W'(CICLOS_DRAIN);
    localparam logic [CANT_BITS_CMD-1:0] CMD_RUN    = CANT_BITS_CMD'(1);
    localparam logic [CANT_BITS_CMD-1:0] CMD_STEP   = CANT_BITS_CMD'(2);
    localparam logic [CANT_BITS_CMD-1:0] CMD_STOP   = CANT_BITS_CMD'(3);

    typedef enum logic [2:0] {IDLE, RUN, STEP, DRAIN, DONE} state_t;

    state_t               state;
    logic [DRAIN_W-1:0]   drain_cnt;
    logic                 cmd_take;

    assign cmd_take = i_cmd_valid && o_cmd_ready;

    always_ff @(posedge i_clock) begin
        if (!i_soft_reset) begin
            state             <= IDLE;
            drain_cnt         <= '0;
            o_enable_pipeline <= 1'b0;
            o_cmd_ready       <= 1'b1;
            o_busy            <= 1'b0;
            o_done            <= 1'b0;
            o_cycle_count     <= '0;
        end else begin
            // Count the cycle that just ended with the enable high; stick at all-ones.
            if (o_enable_pipeline && (o_cycle_count != '1))
                o_cycle_count <= o_cycle_count + CANT_BITS_CONTADOR'(1);

            case (state)
                IDLE: begin
                    if (cmd_take && (i_cmd == CMD_RUN)) begin
                        state             <= RUN;
                        o_enable_pipeline <= 1'b1;
                        o_cmd_ready       <= 1'b1;
                        o_busy            <= 1'b1;
                    end else if (cmd_take && (i_cmd == CMD_STEP)) begin
                        state             <= STEP;
                        o_enable_pipeline <= 1'b1;
                        o_cmd_ready       <= 1'b0;
                        o_busy            <= 1'b1;
                    end
                end

                RUN, STEP: begin
                    // A halt outranks a STOP arriving in the same cycle.
                    if (i_halt_detected) begin
                        o_cmd_ready <= 1'b0;
                        if (CICLOS_DRAIN == 0) begin
                            state             <= DONE;
                            o_enable_pipeline <= 1'b0;
                            o_busy            <= 1'b0;
                            o_done            <= 1'b1;
                        end else begin
                            state             <= DRAIN;
                            drain_cnt         <= DRAIN_LOAD;
                            o_enable_pipeline <= 1'b1;
                            o_busy            <= 1'b1;
                        end
                    end else if ((state == STEP) ||
                                 (cmd_take && (i_cmd == CMD_STOP))) begin
                        state             <= IDLE;
                        o_enable_pipeline <= 1'b0;
                        o_cmd_ready       <= 1'b1;
                        o_busy            <= 1'b0;
                    end
                end

                DRAIN: begin
                    if (drain_cnt == DRAIN_W'(1)) begin
                        state             <= DONE;
                        drain_cnt         <= '0;
                        o_enable_pipeline <= 1'b0;
                        o_busy            <= 1'b0;
                        o_done            <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt - DRAIN_W'(1);
                    end
                end

                DONE: begin
                end

                default: begin
                    state             <= IDLE;
                    drain_cnt         <= '0;
                    o_enable_pipeline <= 1'b0;
                    o_cmd_ready       <= 1'b1;
                    o_busy            <= 1'b0;
                    o_done            <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_control_enable_pipeline.sv
// Testbench for control_enable_pipeline: directed scenarios plus a randomized
// run, all checked against a behavioural model of the command/halt rules.
// A second instance with a 4-bit counter and no drain covers saturation and
// the direct halt-to-DONE path.

module tb_control_enable_pipeline;

    localparam int          DRAIN = 2;
    localparam longint      CMAX  = 64'h0000_0000_FFFF_FFFF;
    localparam logic [1:0]  NOP = 2'b00, RUN = 2'b01, STEP = 2'b10, STOP = 2'b11;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, valid, halt;
    logic [1:0]  cmd;
    logic        en, ready, busy, done;
    logic [31:0] count;

    logic        rst2, valid2, halt2;
    logic [1:0]  cmd2;
    logic        en2, ready2, busy2, done2;
    logic [3:0]  count2;

    control_enable_pipeline #(
        .CANT_BITS_CONTADOR(32), .CANT_BITS_CMD(2), .CICLOS_DRAIN(DRAIN)
    ) dut (
        .i_clock(clk), .i_soft_reset(rst_n), .i_cmd_valid(valid), .i_cmd(cmd),
        .i_halt_detected(halt), .o_enable_pipeline(en), .o_cmd_ready(ready),
        .o_busy(busy), .o_done(done), .o_cycle_count(count)
    );

    control_enable_pipeline #(
        .CANT_BITS_CONTADOR(4), .CANT_BITS_CMD(2), .CICLOS_DRAIN(0)
    ) dut_sat (
        .i_clock(clk), .i_soft_reset(rst2), .i_cmd_valid(valid2), .i_cmd(cmd2),
        .i_halt_detected(halt2), .o_enable_pipeline(en2), .o_cmd_ready(ready2),
        .o_busy(busy2), .o_done(done2), .o_cycle_count(count2)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: what the controller is doing, in plain flags.
    bit     m_run, m_step, m_done;
    int     m_drain;      // enabled drain cycles still owed
    longint m_count;

    function automatic bit m_en();
        return m_run || m_step || (m_drain > 0);
    endfunction

    function automatic void model_reset();
        m_run = 0; m_step = 0; m_done = 0; m_drain = 0; m_count = 0;
    endfunction

    function automatic void model_step(bit v, bit [1:0] c, bit h, bit r);
        if (!r) begin
            model_reset();
            return;
        end
        if (m_en() && m_count < CMAX) m_count++;
        if (m_drain > 0) begin
            m_drain--;
            if (m_drain == 0) m_done = 1;
        end else if ((m_run || m_step) && h) begin
            m_run = 0; m_step = 0;
            if (DRAIN == 0) m_done = 1;
            else m_drain = DRAIN;
        end else if (m_step) begin
            m_step = 0;
        end else if (m_run) begin
            if (v && c == STOP) m_run = 0;
        end else if (!m_done) begin
            if (v && c == RUN)       m_run = 1;
            else if (v && c == STEP) m_step = 1;
        end
    endfunction

    task automatic check_outputs();
        chk("enable", en, m_en());
        chk("ready", ready, !m_done && !m_step && (m_drain == 0));
        chk("busy", busy, m_en());
        chk("done", done, m_done);
        chk("count", count, m_count);
    endtask

    // One clock cycle: check model vs DUT, apply inputs, advance model.
    task automatic cycle(input bit v, input bit [1:0] c, input bit h, input bit r);
        @(negedge clk);
        check_outputs();
        valid = v; cmd = c; halt = h; rst_n = r;
        @(posedge clk);
        model_step(v, c, h, r);
    endtask

    task automatic nops(input int n);
        for (int i = 0; i < n; i++) cycle(0, NOP, 0, 1);
    endtask

    initial begin
        rst_n = 0; valid = 0; cmd = NOP; halt = 0;
        rst2 = 0; valid2 = 0; cmd2 = NOP; halt2 = 0;
        model_reset();
        @(posedge clk);
        #1;
        chk("reset_enable", en, 0);
        chk("reset_ready", ready, 1);
        chk("reset_count", count, 0);

        // RUN at T, halt at T+5: DRAIN two cycles, DONE with 7 enabled cycles
        cycle(0, NOP, 0, 0);
        cycle(1, RUN, 0, 1);
        nops(4);
        cycle(0, NOP, 1, 1);
        nops(2);
        #1;
        chk("halt_run_enable", en, 0);
        chk("halt_run_done", done, 1);
        chk("halt_run_count", count, 7);
        cycle(1, RUN, 0, 1);
        #1;
        chk("done_ignores_run", en, 0);

        // Three spaced STEPs
        cycle(0, NOP, 0, 0);
        for (int k = 0; k < 3; k++) begin
            cycle(1, STEP, 0, 1);
            nops(2);
        end
        #1;
        chk("steps_count", count, 3);
        chk("steps_done", done, 0);
        chk("steps_enable", en, 0);

        // RUN, STOP after 10 enabled cycles, RUN resumes from 10
        cycle(0, NOP, 0, 0);
        cycle(1, RUN, 0, 1);
        nops(9);
        cycle(1, STOP, 0, 1);
        #1;
        chk("stop_enable", en, 0);
        chk("stop_count", count, 10);
        cycle(1, RUN, 0, 1);
        nops(1);
        #1;
        chk("resume_count", count, 11);

        // Halt and STOP in the same RUN cycle: halt wins
        cycle(0, NOP, 0, 0);
        cycle(1, RUN, 0, 1);
        nops(1);
        cycle(1, STOP, 1, 1);
        #1;
        chk("halt_stop_enable", en, 1);
        nops(2);
        #1;
        chk("halt_stop_done", done, 1);

        // STEP with halt in the step cycle, then reset mid-DRAIN
        cycle(0, NOP, 0, 0);
        cycle(1, STEP, 0, 1);
        cycle(0, NOP, 1, 1);
        nops(2);
        cycle(1, STEP, 0, 1);
        #1;
        chk("step_halt_done", done, 1);
        chk("step_halt_count", count, 3);
        cycle(0, NOP, 0, 0);
        cycle(1, STEP, 0, 1);
        cycle(0, NOP, 1, 1);
        cycle(1, RUN, 1, 0);
        #1;
        chk("mid_drain_reset_enable", en, 0);
        chk("mid_drain_reset_count", count, 0);
        chk("mid_drain_reset_ready", ready, 1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cycle(bit'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                  $urandom_range(0, 24) == 0, $urandom_range(0, 79) != 0);
        end
        cycle(0, NOP, 0, 1);

        // Saturating 4-bit counter, no drain
        @(negedge clk);
        rst2 = 1;
        #1;
        chk("sat_reset_count", count2, 0);
        chk("sat_reset_ready", ready2, 1);
        valid2 = 1; cmd2 = RUN;
        @(negedge clk);
        valid2 = 0; cmd2 = NOP;
        repeat (20) @(negedge clk);
        chk("sat_count", count2, 15);
        chk("sat_enable", en2, 1);
        halt2 = 1;
        @(negedge clk);
        halt2 = 0;
        chk("nodrain_done", done2, 1);
        chk("nodrain_enable", en2, 0);
        chk("nodrain_busy", busy2, 0);
        chk("nodrain_count", count2, 15);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
